board_tile_renderer: RTL and testbench
======================================

Name: board_tile_renderer

Overview:
- Read side of the 16x16 game-board BRAM: the board FSM writes a 3-bit colour per cell; this block reads every cell back and paints it as a TILE x TILE square into the VGA adapter, one pixel per cycle.
- One start pulse renders one full board frame; a one-cycle done pulse returns control to the board FSM.
- Sits between the board BRAM read port and the VGA adapter's x/y/colour/plot inputs.

Parameters:
- TILE, 20, tile edge in pixels (>=1).
- X_ORIGIN, 160, pixel x of board top-left; X_ORIGIN+16*TILE <= 640.
- Y_ORIGIN, 80, pixel y of board top-left; Y_ORIGIN+16*TILE <= 480.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request one frame; sampled only in IDLE.
- hold  input  1  VGA back-pressure; freezes painting while high.
- mem_q  input  3  BRAM read data, valid exactly 1 cycle after mem_rden.
- mem_address  output  9  BRAM address = {1'b0, row[3:0], col[3:0]}.
- mem_rden  output  1  BRAM read enable.
- oX  output  10  pixel x to VGA.
- oY  output  9  pixel y to VGA.
- oColour  output  3  pixel colour to VGA.
- plot  output  1  pixel write strobe.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (reset==0 at an edge): state IDLE; cell, px, py, colour_reg cleared; all outputs 0. Applies mid-frame: no further plots, no done pulse.
- States: IDLE, FETCH, WAIT, LATCH, PAINT, DONE.
- IDLE: busy=0. start==1 -> cell=0, FETCH. Otherwise stay.
- FETCH: mem_rden=1, mem_address from cell -> WAIT.
- WAIT: mem_rden=0 (BRAM latency) -> LATCH.
- LATCH: colour_reg <= mem_q; px=py=0 -> PAINT.
- PAINT, hold==0: plot=1, oX=X_ORIGIN+col*TILE+px, oY=Y_ORIGIN+row*TILE+py, oColour=colour_reg. px increments; at px==TILE-1, px->0 and py increments. At px==py==TILE-1: if cell==255 -> DONE, else cell+1 -> FETCH.
- PAINT, hold==1: plot=0; px, py, cell frozen; oX/oY/oColour hold their last values.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy=1 in FETCH, WAIT, LATCH and PAINT.
- Outputs are driven only from registered state, counters and colour_reg; there is no combinational path from inputs to outputs except hold gating plot.
- In non-PAINT states: plot=0, oX/oY/oColour=0.
- Colours pass through unmodified, including 3'b000 and the collision colour 3'b110.
- Arithmetic: col*TILE and row*TILE are computed at 10 bits; the parameter constraints guarantee no overflow. Cell order is raster: col fastest, row = cell[7:4], col = cell[3:0].
- Timing: each cell costs 3 + TILE^2 cycles with hold low. The first cycle after start is sampled is FETCH. done asserts 256*(3+TILE^2) cycles after that cycle begins (103168 at default). Each hold-high cycle during PAINT adds one cycle.
- start while busy: ignored, with no restart and no queueing. start high in the DONE cycle: ignored. start held high continuously: a new frame begins on the cycle after DONE.
- hold outside PAINT: no effect.

Test Plan:
- Reset values: drive reset=0 for 3 cycles with start=1 -> plot, done, busy, mem_rden, oX, oY, oColour all 0; state stays IDLE.
- Full frame, defaults: BRAM model with cell0=3'b100, cell17=3'b001, cell255=3'b110, all others 0. Pulse start. Expect:
  - first plot at oX=160, oY=80, colour 100;
  - cell17 first pixel at oX=180, oY=100, colour 001;
  - final plot at oX=479, oY=399, colour 110;
  - exactly 256*400=102400 plot cycles;
  - done 103168 cycles after FETCH entry.
- Address/latency check, TILE=2: mem_rden pulses 256 times with addresses 0..255 in order. mem_q is changed 2 cycles after each read; the painted colour must equal the value present 1 cycle after rden. Frame length is 1792 cycles.
- Hold: assert hold for 5 cycles mid-cell 3 -> plot=0 and oX/oY frozen during hold; painting resumes at the same pixel; done is delayed by exactly 5 cycles; plot count is unchanged.
- start while busy: pulse start at cycles 10 and 5000 of a frame -> single done; frame length unchanged; busy stays continuously high.
- Reset mid-frame: reset=0 for 1 cycle during cell 100 PAINT -> next cycle IDLE, no done. A new start renders a full frame from cell 0 (first plot at 160,80).

Source files
------------

// File: rtl/board_tile_renderer.sv
// board_tile_renderer
//   Reads every cell of the 16x16 game-board BRAM in raster order and paints
//   it as a TILE x TILE square into the VGA adapter, one pixel per cycle.
//   One start pulse renders one frame; a one-cycle done pulse ends it.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-low
//   start        frame request, sampled only while idle
//   hold         VGA back-pressure, freezes painting while high
//   mem_q        BRAM read data, valid the cycle after mem_rden
//   mem_address  BRAM address {1'b0, row, col}
//   mem_rden     BRAM read enable
//   oX/oY        pixel coordinate to VGA
//   oColour      pixel colour to VGA
//   plot         pixel write strobe
//   busy         high from accepted start until done
//   done         one-cycle end-of-frame pulse
module board_tile_renderer #(
  parameter int TILE     = 20,
  parameter int X_ORIGIN = 160,
  parameter int Y_ORIGIN = 80
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       hold,
  input  logic [2:0] mem_q,
  output logic [8:0] mem_address,
  output logic       mem_rden,
  output logic [9:0] oX,
  output logic [8:0] oY,
  output logic [2:0] oColour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int            PW    = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TILE - 1);
  localparam logic [9:0]    TL10  = 10'(TILE);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LATCH, S_PAINT, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_cell;
  logic [PW-1:0] r_px, r_py;
  logic [2:0]    r_colour;

  logic       w_paint, w_adv, w_px_last, w_py_last;
  logic [9:0] w_col, w_row, w_x, w_y;

  assign w_paint   = (r_state == S_PAINT);
  assign w_adv     = w_paint & ~hold;
  assign w_px_last = (r_px == PLAST);
  assign w_py_last = (r_py == PLAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_LATCH;
      S_LATCH: w_next = S_PAINT;
      S_PAINT: if (w_adv && w_px_last && w_py_last)
                 w_next = (r_cell == 8'd255) ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cell   <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_colour <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) r_cell <= '0;
        // Read data is valid during WAIT and may change afterwards, so the
        // colour is captured on the WAIT->LATCH edge rather than one later.
        S_WAIT: begin
          r_colour <= mem_q;
          r_px     <= '0;
          r_py     <= '0;
        end
        S_PAINT: if (w_adv) begin
          if (w_px_last) begin
            r_px <= '0;
            if (w_py_last) begin
              r_py   <= '0;
              r_cell <= r_cell + 8'd1;  // wraps after cell 255; unused then
            end else begin
              r_py <= r_py + 1'b1;
            end
          end else begin
            r_px <= r_px + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel coordinate is purely a function of the counters, so while hold
  // freezes them the coordinate stays put with no extra registers.
  assign w_col = {6'd0, r_cell[3:0]};
  assign w_row = {6'd0, r_cell[7:4]};
  assign w_x   = 10'(X_ORIGIN) + w_col * TL10 + {{(10-PW){1'b0}}, r_px};
  assign w_y   = 10'(Y_ORIGIN) + w_row * TL10 + {{(10-PW){1'b0}}, r_py};

  assign oX          = w_paint ? w_x : '0;
  assign oY          = w_paint ? 9'(w_y) : '0;
  assign oColour     = w_paint ? r_colour : '0;
  assign plot        = w_adv;
  assign mem_rden    = (r_state == S_FETCH);
  assign mem_address = (r_state == S_FETCH) ? {1'b0, r_cell} : '0;
  assign busy        = (r_state == S_FETCH) || (r_state == S_WAIT) ||
                       (r_state == S_LATCH) || (r_state == S_PAINT);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_board_tile_renderer.sv
module tb_board_tile_renderer;
  localparam int TILE  = 2;
  localparam int FRAME = 256 * (3 + TILE*TILE);   // 1792

  logic       clock = 1'b0;
  logic       reset, start, hold;
  logic [2:0] mem_q = '0;
  logic [8:0] mem_address;
  logic       mem_rden;
  logic [9:0] oX;
  logic [8:0] oY;
  logic [2:0] oColour;
  logic       plot, busy, done;

  board_tile_renderer #(.TILE(TILE), .X_ORIGIN(160), .Y_ORIGIN(80)) dut (
    .clock(clock), .reset(reset), .start(start), .hold(hold), .mem_q(mem_q),
    .mem_address(mem_address), .mem_rden(mem_rden), .oX(oX), .oY(oY),
    .oColour(oColour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // BRAM model: data valid one cycle after rden, then deliberately
  // corrupted the cycle after that to expose late sampling.
  logic [2:0] bram [256];
  logic       rd_d = 1'b0;
  logic [7:0] ad_d = '0;
  always @(posedge clock) begin
    rd_d <= mem_rden;
    ad_d <= mem_address[7:0];
    if (mem_rden)  mem_q <= bram[mem_address[7:0]];
    else if (rd_d) mem_q <= ~bram[ad_d];
  end

  logic rst_seen = 1'b1;
  always @(posedge clock) rst_seen <= reset;

  // scoreboard
  logic [7:0]  exp_addr[$];
  logic [21:0] exp_pix[$];
  int          exp_len[$];
  logic        hold_in_paint = 1'b0;

  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  logic       in_frame = 1'b0, busy_gap = 1'b0, prev_hip = 1'b0;
  int         t0 = 0, plot_cnt = 0, elen;
  logic [9:0] hx;
  logic [8:0] hy;
  always @(negedge clock) begin
    cyc++;
    if (!rst_seen) begin
      chk("reset_outputs", {6'd0, plot, done, busy, mem_rden, oColour, oX, oY}, 0);
      chk("reset_addr", {23'd0, mem_address}, 0);
      exp_addr.delete(); exp_pix.delete(); exp_len.delete();
      in_frame = 1'b0;
    end else begin
      if (!in_frame && busy) begin
        in_frame = 1'b1; t0 = cyc; plot_cnt = 0; busy_gap = 1'b0;
      end
      if (mem_rden) begin
        chk("addr_q_nonempty", {31'd0, exp_addr.size() > 0}, 1);
        if (exp_addr.size() > 0) chk("read_addr", {23'd0, mem_address}, {24'd0, exp_addr.pop_front()});
      end
      if (plot) begin
        plot_cnt++;
        chk("pix_q_nonempty", {31'd0, exp_pix.size() > 0}, 1);
        if (exp_pix.size() > 0) chk("pixel", {10'd0, oX, oY, oColour}, {10'd0, exp_pix.pop_front()});
      end
      if (hold_in_paint) begin
        chk("plot_during_hold", {31'd0, plot}, 0);
        if (!prev_hip) begin hx = oX; hy = oY; end
        else chk("xy_frozen", {13'd0, oX, oY}, {13'd0, hx, hy});
      end
      prev_hip = hold_in_paint;
      if (in_frame && !busy && !done) busy_gap = 1'b1;
      if (done) begin
        chk("done_in_frame", {31'd0, in_frame}, 1);
        if (in_frame) begin
          elen = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
          chk("frame_len", cyc - t0, elen);
          chk("plot_count", plot_cnt, 256*TILE*TILE);
          chk("addr_q_drained", exp_addr.size(), 0);
          chk("pix_q_drained", exp_pix.size(), 0);
          chk("busy_continuous", {31'd0, busy_gap}, 0);
          chk("busy_low_at_done", {31'd0, busy}, 0);
        end
        in_frame = 1'b0;
        done_cnt++;
      end
    end
  end

  // stimulus
  task automatic push_frame(int len);
    for (int c = 0; c < 256; c++) begin
      exp_addr.push_back(8'(c));
      for (int py = 0; py < TILE; py++)
        for (int px = 0; px < TILE; px++)
          exp_pix.push_back({10'(160 + (c % 16)*TILE + px),
                             9'(80 + (c / 16)*TILE + py), bram[c]});
    end
    exp_len.push_back(len);
  endtask

  // Leaves the caller #1 into the first FETCH cycle.
  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < FRAME + 500; i++) begin
      @(posedge clock);
      if (done_cnt != c0) break;
    end
    if (done_cnt == c0) begin
      $display("FAIL wait_done: no done within %0d cycles", FRAME + 500);
      $fatal(1, "timeout");
    end
    #1;
  endtask

  task automatic load_pattern_a();
    for (int c = 0; c < 256; c++) bram[c] = 3'b000;
    bram[0] = 3'b100; bram[17] = 3'b001; bram[255] = 3'b110;
  endtask

  task automatic load_pattern_b();
    for (int c = 0; c < 256; c++) bram[c] = 3'(c ^ (c >> 3));
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; hold = 1'b0;
    load_pattern_a();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clock);

    // full frame, sparse colours (first 160,80/100; cell17 162,82/001; last 191,111/110)
    push_frame(FRAME); pulse_start(); wait_done();

    // every cell a different colour, checks read order and capture timing
    load_pattern_b();
    push_frame(FRAME); pulse_start(); wait_done();

    // hold for 5 cycles in the middle of cell 3's paint
    push_frame(FRAME + 5); pulse_start();
    repeat (25) @(posedge clock);
    #1 hold = 1'b1; hold_in_paint = 1'b1;
    repeat (5) @(posedge clock);
    #1 hold = 1'b0; hold_in_paint = 1'b0;
    wait_done();

    // start pulses while busy are ignored
    push_frame(FRAME); pulse_start();
    repeat (10) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (989) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done();
    repeat (20) @(posedge clock);

    // reset during cell 100 paint, then a clean frame from cell 0
    load_pattern_a();
    push_frame(FRAME); pulse_start();
    repeat (704) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    push_frame(FRAME); pulse_start(); wait_done();
    repeat (5) @(posedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
